// File: rtl/mmb_slave_ram_pkg.sv
// mmb_slave_ram_pkg
//   Shared types and constants for the MemoryMapped burst RAM responder.
//   - state_t    : responder FSM states
//   - LFSR_SEED  : reset value of the busy-injection LFSR
//   - LFSR_TAPS  : feedback mask for taps 16,14,13,11 (bit positions 15,13,12,10)
//   The LFSR constants are only consumed when MMB_SLAVE_RAM_BUSY_INJECT_EN is defined.
package mmb_slave_ram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2
  } state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/mmb_slave_ram_if.sv
// mmb_slave_ram_if
//   MemoryMapped burst bus bundle.
//   addr  : burst start address (held by the master for a whole write burst)
//   bcnt  : burst length, 0 means 2**BWIDTH beats
//   wreq  : write beat request        wdat : write beat data
//   rreq  : read burst request (one per burst)
//   rdat  : read response data       rval : read response valid (no backpressure)
//   busy  : request not accepted this cycle
//   Modports: master drives requests, slave drives responses and busy.
interface mmb_slave_ram_if #(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 32,
  parameter int BWIDTH = 32
);

  logic [AWIDTH-1:0] addr;
  logic [BWIDTH-1:0] bcnt;
  logic              wreq;
  logic [DWIDTH-1:0] wdat;
  logic              rreq;
  logic [DWIDTH-1:0] rdat;
  logic              rval;
  logic              busy;

  modport master (
    output addr, bcnt, wreq, wdat, rreq,
    input  rdat, rval, busy
  );

  modport slave (
    input  addr, bcnt, wreq, wdat, rreq,
    output rdat, rval, busy
  );

endinterface

// File: rtl/mmb_slave_ram_sp_ram.sv
// mmb_sp_ram
//   Single-port RAM of 2**AWIDTH words with a registered read port.
//   clk  : clock
//   we   : write enable, writes wdat to mem[addr]
//   addr : shared read/write index
//   wdat : write data
//   re   : read enable; rdat only updates when re=1, otherwise it holds
//   rdat : registered read data
//   Contents and rdat are not reset.
module mmb_sp_ram #(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AWIDTH-1:0] addr,
  input  logic [DWIDTH-1:0] wdat,
  input  logic              re,
  output logic [DWIDTH-1:0] rdat
);

  logic [DWIDTH-1:0] mem [2**AWIDTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdat;
    end
    if (re) begin
      rdat <= mem[addr];
    end
  end

endmodule

// File: rtl/mmb_slave_ram.sv
// mmb_slave_ram
//   MemoryMapped burst responder backed by a 2**RAM_AWIDTH-word single-port RAM.
//   Write bursts are taken beat by beat; read bursts stream one response per
//   cycle, in address order, one cycle after each RAM read is issued.
//   Ports:
//     clk   : clock
//     reset : synchronous reset, active low
//     s     : mmb_slave_ram_if.slave (addr/bcnt/wreq/wdat/rreq/rdat/rval/busy)
//   Only addr[RAM_AWIDTH-1:0] is used; burst addresses wrap modulo 2**RAM_AWIDTH.
//   Build option: MMB_SLAVE_RAM_BUSY_INJECT_EN adds an LFSR that raises busy
//   on ~25% of IDLE/WRITE cycles to stress masters.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   ST_IDLE  | waiting for a write beat or read request
//   ST_WRITE | inside a multi-beat write burst, waiting for next beat
//   ST_READ  | issuing one RAM read per cycle, busy held high
module mmb_slave_ram
  import mmb_slave_ram_pkg::*;
#(
  parameter int DWIDTH     = 8,
  parameter int AWIDTH     = 32,
  parameter int BWIDTH     = 32,
  parameter int RAM_AWIDTH = 10
) (
  input  logic           clk,
  input  logic           reset,
  mmb_slave_ram_if.slave s
);

  state_t                state_q, state_d;
  logic [RAM_AWIDTH-1:0] base_q, base_d;
  logic [RAM_AWIDTH-1:0] off_q, off_d;
  logic [BWIDTH-1:0]     rem_q, rem_d;
  logic                  rval_q;
  logic                  busy;

  logic                  ram_we;
  logic                  ram_re;
  logic [RAM_AWIDTH-1:0] ram_addr;
  logic [DWIDTH-1:0]     ram_rdat;

  logic                  unused_addr_hi;
  assign unused_addr_hi = ^s.addr[AWIDTH-1:RAM_AWIDTH];

`ifdef MMB_SLAVE_RAM_BUSY_INJECT_EN
  logic [15:0] lfsr_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
    end
  end

  // READ is already busy; injection only matters in IDLE/WRITE.
  assign busy = (state_q == ST_READ) || (lfsr_q[1:0] == 2'b00);
`else
  assign busy = (state_q == ST_READ);
`endif

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    off_d    = off_q;
    rem_d    = rem_q;
    ram_we   = 1'b0;
    ram_re   = 1'b0;
    ram_addr = base_q + off_q;

    unique case (state_q)
      ST_IDLE: begin
        if (!busy) begin
          if (s.wreq) begin
            // First beat goes straight to the RAM at the bus address.
            ram_we   = 1'b1;
            ram_addr = s.addr[RAM_AWIDTH-1:0];
            base_d   = s.addr[RAM_AWIDTH-1:0];
            rem_d    = s.bcnt - BWIDTH'(1);
            off_d    = RAM_AWIDTH'(1);
            if (s.bcnt != BWIDTH'(1)) begin
              state_d = ST_WRITE;
            end
          end else if (s.rreq) begin
            // bcnt==0 leaves rem at 0, which wraps to 2**BWIDTH reads.
            base_d  = s.addr[RAM_AWIDTH-1:0];
            rem_d   = s.bcnt;
            off_d   = '0;
            state_d = ST_READ;
          end
        end
      end

      ST_WRITE: begin
        // rreq here is a protocol violation and is simply not accepted.
        if (!busy && s.wreq) begin
          ram_we = 1'b1;
          off_d  = off_q + RAM_AWIDTH'(1);
          rem_d  = rem_q - BWIDTH'(1);
          if (rem_q == BWIDTH'(1)) begin
            state_d = ST_IDLE;
          end
        end
      end

      ST_READ: begin
        ram_re = 1'b1;
        off_d  = off_q + RAM_AWIDTH'(1);
        rem_d  = rem_q - BWIDTH'(1);
        if (rem_q == BWIDTH'(1)) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      base_q  <= '0;
      off_q   <= '0;
      rem_q   <= '0;
      rval_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      off_q   <= off_d;
      rem_q   <= rem_d;
      rval_q  <= ram_re;
    end
  end

  mmb_sp_ram #(
    .DWIDTH (DWIDTH),
    .AWIDTH (RAM_AWIDTH)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .addr (ram_addr),
    .wdat (s.wdat),
    .re   (ram_re),
    .rdat (ram_rdat)
  );

  // RAM output register is not reset, so rdat is forced to 0 outside responses.
  assign s.busy = busy;
  assign s.rval = rval_q;
  assign s.rdat = rval_q ? ram_rdat : '0;

endmodule

// File: tb/tb_mmb_slave_ram.sv
module tb_mmb_slave_ram;

  logic clk;
  logic reset;

  mmb_slave_ram_if #(.DWIDTH(8), .AWIDTH(32), .BWIDTH(32)) bus ();

  mmb_slave_ram #(
    .DWIDTH     (8),
    .AWIDTH     (32),
    .BWIDTH     (32),
    .RAM_AWIDTH (10)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .s     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         checks = 0;
  int         failures = 0;
  int         busy_waits = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mdl [1024];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every response must match the oldest expected word.
  always @(negedge clk) begin
    if (bus.rval === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL rval_unexpected actual rdat=0x%0h expected no response", bus.rdat);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (bus.rdat !== e) begin
          failures++;
          $display("FAIL rdat actual=0x%0h expected=0x%0h", bus.rdat, e);
        end
      end
    end
  end

  // Holds one request until accepted; returns at posedge+1 after acceptance.
  task automatic beat(input logic w, input logic r, input logic [31:0] a,
                      input logic [31:0] b, input logic [7:0] d);
    logic bz;
    int   n;
    bus.wreq = w; bus.rreq = r; bus.addr = a; bus.bcnt = b; bus.wdat = d;
    n = 0;
    do begin
      @(negedge clk);
      bz = bus.busy;
      if (bz && w) busy_waits++;
      @(posedge clk);
      #1;
      n++;
    end while (bz && n < 200);
    if (bz) check("accept_timeout", {31'd0, bz}, 32'd0);
    bus.wreq = 1'b0;
    bus.rreq = 1'b0;
  endtask

  task automatic write_burst(input logic [31:0] a, input int n, input logic [7:0] d0, input int gap);
    for (int i = 0; i < n; i++) begin
      beat(1'b1, 1'b0, a, n, d0 + 8'(i));
      mdl[10'(a + 32'(i))] = d0 + 8'(i);
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic push_exp(input logic [31:0] a, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(mdl[10'(a + 32'(i))]);
  endtask

  // Issues a read burst and checks busy window length and response timing.
  task automatic read_timed(input string tag, input logic [31:0] a, input int b);
    int nbusy, nrval, first, last;
    push_exp(a, b);
    beat(1'b0, 1'b1, a, b, 8'h00);
    nbusy = 0; nrval = 0; first = -1; last = -1;
    for (int k = 0; k < b + 3; k++) begin
      @(negedge clk);
      if (bus.busy) nbusy++;
      if (bus.rval) begin
        if (first < 0) first = k;
        last = k;
        nrval++;
      end
    end
    check({tag, "_busy_cycles"}, nbusy, b);
    check({tag, "_rval_count"}, nrval, b);
    check({tag, "_first_rval"}, first, 1);
    check({tag, "_rval_contig"}, last - first + 1, b);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nbusy, nrval, n;

    reset = 1'b0;
    bus.addr = '0; bus.bcnt = '0; bus.wreq = 1'b0; bus.wdat = '0; bus.rreq = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", {31'd0, bus.busy}, 32'd0);
    check("reset_rval", {31'd0, bus.rval}, 32'd0);
    check("reset_rdat", {24'd0, bus.rdat}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Single-beat write and read.
    write_burst(32'h10, 1, 8'hA5, 0);
    read_timed("single", 32'h10, 1);

    // Gapped write burst across the top of the RAM, then read back.
    write_burst(32'h3FE, 4, 8'h01, 2);
    read_timed("wrap", 32'h3FE, 4);
    check("wrap_mdl_000", {24'd0, mdl[0]}, 32'h03);

    // 8-beat read; write into the last-response cycle, then read it back at once.
    write_burst(32'h200, 8, 8'h30, 0);
    push_exp(32'h200, 8);
    beat(1'b0, 1'b1, 32'h200, 8, 8'h00);
    nbusy = 0; nrval = 0; n = 0;
    do begin
      @(negedge clk);
      if (bus.busy) nbusy++;
      if (bus.rval) nrval++;
      n++;
    end while (bus.busy && n < 30);
    check("win_busy_cycles", nbusy, 8);
    check("win_rval_total", nrval, 8);
    check("win_last_rdat", {24'd0, bus.rdat}, 32'h37);
    bus.wreq = 1'b1; bus.addr = 32'h207; bus.bcnt = 1; bus.wdat = 8'hEE;
    mdl[10'h207] = 8'hEE;
    @(posedge clk);
    #1;
    bus.wreq = 1'b0;
    @(negedge clk);
    check("win_rval_after", {31'd0, bus.rval}, 32'd0);
    @(posedge clk);
    #1;
    read_timed("wr2rd", 32'h207, 1);

    // Reset in the middle of a 10-beat read.
    write_burst(32'h300, 10, 8'h50, 0);
    push_exp(32'h300, 10);
    beat(1'b0, 1'b1, 32'h300, 10, 8'h00);
    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    check("rst_dropped", exp_q.size(), 7);
    exp_q.delete();
    @(negedge clk);
    check("rst_rval", {31'd0, bus.rval}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    @(posedge clk);
    #1;
    read_timed("rst_reread", 32'h300, 10);

    // rreq during a write burst is not accepted; addr/bcnt are not re-sampled.
    mdl[10'h40] = 8'h00;
    beat(1'b1, 1'b0, 32'h80, 3, 8'h61);
    mdl[10'h80] = 8'h61;
    bus.rreq = 1'b1; bus.addr = 32'h40; bus.bcnt = 5;
    nbusy = 0; nrval = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.busy) nbusy++;
      if (bus.rval) nrval++;
      @(posedge clk);
      #1;
    end
    bus.rreq = 1'b0;
    @(negedge clk);
    if (bus.rval) nrval++;
    check("viol_rval", nrval, 0);
`ifndef MMB_SLAVE_RAM_BUSY_INJECT_EN
    check("viol_busy", nbusy, 0);
`endif
    @(posedge clk);
    #1;
    beat(1'b1, 1'b0, 32'h0, 0, 8'h62);
    mdl[10'h81] = 8'h62;
    beat(1'b1, 1'b0, 32'h0, 0, 8'h63);
    mdl[10'h82] = 8'h63;
    read_timed("viol_read", 32'h80, 3);

    // 200 random single-beat writes, then one burst read of them all.
    for (int i = 0; i < 200; i++) begin
      logic [7:0] d;
      d = 8'($urandom);
      beat(1'b1, 1'b0, 32'h100 + 32'(i), 1, d);
      mdl[10'(32'h100 + 32'(i))] = d;
    end
    read_timed("rand", 32'h100, 200);
`ifdef MMB_SLAVE_RAM_BUSY_INJECT_EN
    check("inject_busy_seen", {31'd0, busy_waits > 0}, 32'd1);
`endif

    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
